// File: rtl/median_window_feeder.sv
// Producer side of the median filter handshake. Streams raster pixels into two
// line buffers and a 3x3 window, serializes each interior window as a 9-cycle
// strobe burst, then holds off the pixel source until the median unit finishes.
module median_window_feeder #(
  parameter int W     = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [W-1:0]             PI,
  input  logic                     PV,
  output logic                     PREADY,
  output logic [W-1:0]             DO,
  output logic                     DSO,
  input  logic                     MDONE,
  output logic [$clog2(IMG_W)-1:0] WX,
  output logic [$clog2(IMG_H)-1:0] WY,
  output logic                     BUSY
);

  // state | meaning
  // IDLE  | accepting pixels, one per cycle
  // SEND  | 9-cycle window burst on DO/DSO
  // WAIT  | burst done, waiting for the median unit's completion pulse

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0]    burst;
  logic [W-1:0]  lb0 [IMG_W];
  logic [W-1:0]  lb1 [IMG_W];
  logic [W-1:0]  win [9];
  logic          accept;
  logic          win_done;

  // A pixel is taken only in IDLE and never while reset is asserted.
  assign accept   = (state == IDLE) && PV && !RST;
  assign win_done = accept && (row >= RW'(2)) && (col >= CW'(2));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    PREADY    = 1'b0;
    BUSY      = 1'b1;
    DSO       = 1'b0;
    DO        = '0;
    case (state)
      IDLE: begin
        PREADY = 1'b1;
        BUSY   = 1'b0;
        if (win_done) state_nxt = SEND;
      end
      SEND: begin
        DSO = 1'b1;
        DO  = win[burst];
        if (burst == 4'd8) state_nxt = WAIT;
      end
      WAIT: begin
        if (MDONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst position within the 9-pixel window; idles at zero outside SEND.
  always_ff @(posedge CLK) begin
    if (RST)                 burst <= 4'd0;
    else if (state != SEND)  burst <= 4'd0;
    else if (burst == 4'd8)  burst <= 4'd0;
    else                     burst <= burst + 4'd1;
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window centre, latched with the pixel that completes a window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WX <= '0;
      WY <= '0;
    end else if (win_done) begin
      WX <= col - CW'(1);
      WY <= row - RW'(1);
    end
  end

  // Line buffers and window shift; contents are don't-care until overwritten.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb0[col] <= PI;
      lb1[col] <= lb0[col];
      win[0]   <= win[1];
      win[1]   <= win[2];
      win[2]   <= lb1[col];
      win[3]   <= win[4];
      win[4]   <= win[5];
      win[5]   <= lb0[col];
      win[6]   <= win[7];
      win[7]   <= win[8];
      win[8]   <= PI;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder: a 4x4 instance with a scoreboard of expected
// windows, and an 8x3 10-bit instance fed with all-ones pixels.
module tb_median_window_feeder;

  localparam int MD_DLY_A = 20;
  localparam int MD_DLY_B = 3;

  typedef struct packed {
    logic [8:0][7:0] px;
    logic [31:0]     wx;
    logic [31:0]     wy;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_pv, a_md, a_pready, a_dso, a_busy;
  logic       a_auto, a_md_auto, a_md_man;
  logic [7:0] a_pi, a_do;
  logic [1:0] a_wx, a_wy;

  logic       b_rst, b_pv, b_md, b_pready, b_dso, b_busy;
  logic [9:0] b_pi, b_do;
  logic [2:0] b_wx;
  logic [1:0] b_wy;

  assign a_md = a_auto ? a_md_auto : a_md_man;

  median_window_feeder #(.W(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .CLK(clk), .RST(a_rst), .PI(a_pi), .PV(a_pv), .PREADY(a_pready),
    .DO(a_do), .DSO(a_dso), .MDONE(a_md), .WX(a_wx), .WY(a_wy), .BUSY(a_busy)
  );

  median_window_feeder #(.W(10), .IMG_W(8), .IMG_H(3)) dut_b (
    .CLK(clk), .RST(b_rst), .PI(b_pi), .PV(b_pv), .PREADY(b_pready),
    .DO(b_do), .DSO(b_dso), .MDONE(b_md), .WX(b_wx), .WY(b_wy), .BUSY(b_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  win_t exp_a[$];
  int   exp_b[$];
  int   img_a [4][4];
  int   a_prev_win = 0;

  // Median unit models: pulse MDONE a fixed number of WAIT cycles after a burst.
  int a_wcnt = 0;
  always @(negedge clk) begin
    if (a_busy && !a_dso) begin
      a_wcnt++;
      a_md_auto = (a_wcnt == MD_DLY_A);
    end else begin
      a_wcnt = 0;
      a_md_auto = 1'b0;
    end
  end

  int b_wcnt = 0;
  always @(negedge clk) begin
    if (b_busy && !b_dso) begin
      b_wcnt++;
      b_md = (b_wcnt == MD_DLY_B);
    end else begin
      b_wcnt = 0;
      b_md = 1'b0;
    end
  end

  // Monitor A: collect each burst, compare against the oldest expected window.
  logic [7:0] a_got [9];
  int         a_cnt = 0;
  int         a_nwin = 0;
  always @(posedge clk) begin
    win_t e;
    #1;
    if (a_rst) begin
      a_cnt = 0;
    end else if (a_dso) begin
      if (a_cnt < 9) a_got[a_cnt] = a_do;
      a_cnt++;
    end else if (a_cnt != 0) begin
      chk("a_burst_len", a_cnt, 9);
      chk("a_win_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        for (int i = 0; i < 9; i++)
          chk($sformatf("a_do[%0d]", i), 32'(a_got[i]), 32'(e.px[i]));
        chk("a_wx", 32'(a_wx), e.wx);
        chk("a_wy", 32'(a_wy), e.wy);
      end
      a_nwin++;
      a_cnt = 0;
    end
  end

  // Monitor B: every strobed pixel must be all-ones; WX follows the queue.
  int b_cnt = 0;
  int b_nwin = 0;
  always @(posedge clk) begin
    #1;
    if (b_rst) begin
      b_cnt = 0;
    end else if (b_dso) begin
      chk("b_do", 32'(b_do), 32'h3FF);
      b_cnt++;
    end else if (b_cnt != 0) begin
      chk("b_burst_len", b_cnt, 9);
      chk("b_win_expected", 32'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) chk("b_wx", 32'(b_wx), exp_b.pop_front());
      chk("b_wy", 32'(b_wy), 1);
      b_nwin++;
      b_cnt = 0;
    end
  end

  // Offer one pixel to A starting at a negedge; returns one negedge after acceptance.
  task automatic push_a(input int v, input int r, input int c, output int waits);
    win_t e;
    a_pi  = 8'(v);
    a_pv  = 1'b1;
    waits = 0;
    while (!a_pready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!a_pready) chk("a_pready_timeout", 32'(a_pready), 1);
    img_a[r][c] = v;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) e.px[k] = 8'(img_a[r - 2 + k / 3][c - 2 + k % 3]);
      e.wx = 32'(c - 1);
      e.wy = 32'(r - 1);
      exp_a.push_back(e);
    end
    @(negedge clk);
  endtask

  // Full 4x4 frame with PV held high; checks the stall after every window.
  task automatic stream_a(input int base);
    int waits;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        push_a(base + 4 * r + c, r, c, waits);
        chk($sformatf("a_stall r%0d c%0d", r, c), waits, (a_prev_win != 0) ? 9 + MD_DLY_A : 0);
        a_prev_win = (r >= 2 && c >= 2) ? 1 : 0;
      end
    end
  endtask

  task automatic idle_a();
    int n = 0;
    a_pv = 1'b0;
    while (a_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("a_idle_timeout", 32'(a_busy), 0);
    @(negedge clk);
    @(negedge clk);
    chk("a_exp_drained", exp_a.size(), 0);
  endtask

  task automatic reset_a();
    a_pv  = 1'b0;
    a_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    exp_a.delete();
    a_prev_win = 0;
  endtask

  task automatic push_b(input int r, input int c);
    int n = 0;
    b_pv = 1'b1;
    while (!b_pready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!b_pready) chk("b_pready_timeout", 32'(b_pready), 1);
    if (r >= 2 && c >= 2) exp_b.push_back(c - 1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int waits;
    int n;
    a_rst = 1'b1; a_pv = 1'b1; a_pi = 8'd77; a_auto = 1'b1; a_md_man = 1'b0;
    b_rst = 1'b1; b_pv = 1'b1; b_pi = 10'h3FF;
    repeat (3) @(negedge clk);

    // Reset values, with PV asserted to show nothing is taken during reset.
    chk("rst_dso", 32'(a_dso), 0);
    chk("rst_do", 32'(a_do), 0);
    chk("rst_wx", 32'(a_wx), 0);
    chk("rst_wy", 32'(a_wy), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_pready", 32'(a_pready), 1);
    chk("rst_b_busy", 32'(b_busy), 0);
    chk("rst_b_pready", 32'(b_pready), 1);
    a_pv = 1'b0; b_pv = 1'b0;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Two frames back to back; the second frame is offset by 100.
    base = a_nwin;
    stream_a(0);
    stream_a(100);
    idle_a();
    chk("a_nwin_two_frames", a_nwin - base, 8);

    // MDONE held through the whole burst, then a late single pulse.
    reset_a();
    a_auto = 1'b0;
    for (int k = 0; k < 11; k++) push_a(k, k / 4, k % 4, waits);
    a_pv = 1'b0;
    a_md_man = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("spur_dso", 32'(a_dso), 1);
      @(negedge clk);
    end
    a_md_man = 1'b0;
    chk("spur_dso_low", 32'(a_dso), 0);
    chk("spur_do_wait", 32'(a_do), 0);
    for (int i = 0; i < 5; i++) begin
      chk("spur_busy", 32'(a_busy), 1);
      @(negedge clk);
    end
    a_md_man = 1'b1;
    chk("spur_busy_pulse", 32'(a_busy), 1);
    @(negedge clk);
    a_md_man = 1'b0;
    chk("spur_idle_busy", 32'(a_busy), 0);
    chk("spur_idle_pready", 32'(a_pready), 1);
    a_auto = 1'b1;

    // Reset on the 4th SEND cycle, then a clean frame from (0,0).
    reset_a();
    for (int k = 0; k < 11; k++) push_a(k, k / 4, k % 4, waits);
    a_pv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_dso_before", 32'(a_dso), 1);
    a_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_dso", 32'(a_dso), 0);
    chk("rst_mid_pready", 32'(a_pready), 1);
    chk("rst_mid_busy", 32'(a_busy), 0);
    a_rst = 1'b0;
    exp_a.delete();
    a_prev_win = 0;
    @(negedge clk);
    base = a_nwin;
    stream_a(0);
    idle_a();
    chk("a_nwin_after_rst", a_nwin - base, 4);

    // 10-bit pixels on an 8x3 image.
    base = b_nwin;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++) push_b(r, c);
    b_pv = 1'b0;
    n = 0;
    while (b_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle_timeout", 32'(b_busy), 0);
    @(negedge clk);
    @(negedge clk);
    chk("b_nwin", b_nwin - base, 6);
    chk("b_exp_drained", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
